sign_extend: RTL and testbench

//   Immediate-field extender for the 16-bit ISA datapath. Widens the 5-bit

---
 rtl/isa_pkg.sv | 11 +
 rtl/sign_extend_core.sv | 24 ++
 rtl/sign_extend.sv | 65 ++++++
 tb/tb_sign_extend.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA datapath definitions: default immediate/operand widths and the
// field types reused by decode and the immediate extender.
package isa_pkg;

  localparam int unsigned DEF_IMM_W = 5;
  localparam int unsigned DEF_OUT_W = 16;

  typedef logic [DEF_IMM_W-1:0] imm_t;
  typedef logic [DEF_OUT_W-1:0] word_t;

endpackage : isa_pkg

// File: rtl/sign_extend_core.sv
// Combinational immediate widener: sign or zero extension, then an optional
// left shift by one for branch offsets (the shifted-out MSB is dropped).
module sign_extend_core
  import isa_pkg::*;
#(
  parameter int unsigned IMM_W = DEF_IMM_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic [IMM_W-1:0] Immediate,
  input  logic             ZeroExt,
  input  logic             Shift1,
  output logic [OUT_W-1:0] Result
);

  localparam int unsigned PAD_W = OUT_W - IMM_W;

  logic             fill_bit;
  logic [OUT_W-1:0] ext;

  assign fill_bit = ZeroExt ? 1'b0 : Immediate[IMM_W-1];
  assign ext      = {{PAD_W{fill_bit}}, Immediate};
  assign Result   = Shift1 ? {ext[OUT_W-2:0], 1'b0} : ext;

endmodule : sign_extend_core

// File: rtl/sign_extend.sv
// Registered immediate extender: one cycle from the ImmValid capture edge to
// Extended/ExtValid; Extended holds between captures.
module sign_extend
  import isa_pkg::*;
#(
  parameter int unsigned IMM_W = DEF_IMM_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IMM_W-1:0] Immediate,
  input  logic             ImmValid,
  input  logic             ZeroExt,
  input  logic             Shift1,
  output logic [OUT_W-1:0] Extended,
  output logic             ExtValid
);

  if (IMM_W < 2 || IMM_W >= OUT_W) begin : g_bad_width
    $error("sign_extend: IMM_W must be >= 2 and < OUT_W");
  end

  logic [OUT_W-1:0] res;
  logic [OUT_W-1:0] extended_d, extended_q;
  logic             ext_valid_d, ext_valid_q;
  // Low through the reset-release edge so a capture coinciding with it is ignored.
  logic             armed_q;

  sign_extend_core #(
    .IMM_W(IMM_W),
    .OUT_W(OUT_W)
  ) u_core (
    .Immediate(Immediate),
    .ZeroExt  (ZeroExt),
    .Shift1   (Shift1),
    .Result   (res)
  );

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    extended_d  = extended_q;
    ext_valid_d = 1'b0;
    if (armed_q && ImmValid) begin
      extended_d  = res;
      ext_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      extended_q  <= '0;
      ext_valid_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      extended_q  <= extended_d;
      ext_valid_q <= ext_valid_d;
      armed_q     <= 1'b1;
    end
  end

  assign Extended = extended_q;
  assign ExtValid = ext_valid_q;

endmodule : sign_extend

// File: tb/tb_sign_extend.sv
// Scoreboard bench for sign_extend: the driver queues the expected post-edge
// state each cycle, an independent monitor pops and compares after each edge.
module tb_sign_extend;
  import isa_pkg::*;

  localparam int unsigned IMM_W = DEF_IMM_W;
  localparam int unsigned OUT_W = DEF_OUT_W;

  logic  clk;
  logic  rst_n;
  imm_t  Immediate;
  logic  ImmValid;
  logic  ZeroExt;
  logic  Shift1;
  word_t Extended;
  logic  ExtValid;

  typedef struct packed {
    logic  valid;
    word_t value;
  } exp_t;

  exp_t  sb_q[$];
  word_t model_q;
  int    tests;
  int    fails;

  sign_extend #(
    .IMM_W(IMM_W),
    .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Immediate(Immediate),
    .ImmValid (ImmValid),
    .ZeroExt  (ZeroExt),
    .Shift1   (Shift1),
    .Extended (Extended),
    .ExtValid (ExtValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the immediate as an integer (two's complement unless
  // zero-extending), double it for branch offsets, keep the low OUT_W bits.
  function automatic word_t ref_model(input imm_t imm, input bit ze, input bit sh);
    int v;
    v = int'(imm);
    if (!ze && v >= (1 << (IMM_W - 1))) v = v - (1 << IMM_W);
    if (sh) v = v * 2;
    return word_t'(v);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (sb_q.size() == 0) begin
        check("sb_underrun", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("ext_valid", 32'(ExtValid), 32'(e.valid));
        check("extended", 32'(Extended), 32'(e.value));
      end
    end
  end

  task automatic issue(input bit v, input imm_t imm, input bit ze, input bit sh,
                       input word_t exp_val);
    @(negedge clk);
    ImmValid  = v;
    Immediate = imm;
    ZeroExt   = ze;
    Shift1    = sh;
    if (v) model_q = exp_val;
    sb_q.push_back(exp_t'{valid: v, value: model_q});
  endtask

  // Release at a negedge with a valid immediate present; that edge must not capture.
  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    ImmValid  = 1'b1;
    Immediate = '1;
    ZeroExt   = 1'b0;
    Shift1    = 1'b0;
    sb_q.push_back(exp_t'{valid: 1'b0, value: '0});
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_extended", 32'(Extended), 32'h0);
    check("midrst_ext_valid", 32'(ExtValid), 32'h0);
    sb_q.delete();
    model_q = '0;
  endtask

  task automatic rand_cycle();
    imm_t imm;
    bit   v, ze, sh;
    imm = imm_t'($urandom);
    v   = ($urandom_range(0, 3) != 0);
    ze  = $urandom_range(0, 1) == 1;
    sh  = $urandom_range(0, 1) == 1;
    issue(v, imm, ze, sh, ref_model(imm, ze, sh));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    model_q   = '0;
    rst_n     = 1'b0;
    ImmValid  = 1'b0;
    Immediate = '0;
    ZeroExt   = 1'b0;
    Shift1    = 1'b0;
    #2;
    check("por_extended", 32'(Extended), 32'h0);
    check("por_ext_valid", 32'(ExtValid), 32'h0);
    release_reset();

    issue(1'b1, 5'b10010, 1'b0, 1'b0, 16'hFFF2);
    issue(1'b1, 5'b00010, 1'b0, 1'b0, 16'h0002);
    issue(1'b0, 5'b11011, 1'b1, 1'b1, 16'h0000);
    issue(1'b0, 5'b10101, 1'b0, 1'b1, 16'h0000);
    issue(1'b1, 5'b10010, 1'b1, 1'b0, 16'h0012);
    issue(1'b1, 5'b11111, 1'b0, 1'b0, 16'hFFFF);
    issue(1'b1, 5'b10010, 1'b0, 1'b1, 16'hFFE4);
    issue(1'b1, 5'b01111, 1'b0, 1'b1, 16'h001E);
    issue(1'b1, 5'b10000, 1'b0, 1'b0, 16'hFFF0);
    issue(1'b1, 5'b01111, 1'b0, 1'b0, 16'h000F);
    issue(1'b1, 5'b10000, 1'b0, 1'b1, 16'hFFE0);
    issue(1'b1, 5'b11111, 1'b1, 1'b1, 16'h003E);
    for (int m = 0; m < 4; m++) begin
      issue(1'b1, 5'b00000, m[0], m[1], 16'h0000);
    end

    for (int m = 0; m < 4; m++) begin
      for (int c = 0; c < 32; c++) begin
        imm_t imm;
        imm = imm_t'(c);
        issue(1'b1, imm, m[0], m[1], ref_model(imm, m[0], m[1]));
        if (c % 7 == 3) issue(1'b0, imm_t'($urandom), $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1, '0);
      end
    end

    for (int i = 0; i < 150; i++) rand_cycle();

    issue(1'b1, 5'b11111, 1'b0, 1'b0, 16'hFFFF);
    reset_mid_cycle();
    release_reset();
    issue(1'b0, 5'b00101, 1'b0, 1'b0, '0);
    issue(1'b1, 5'b00101, 1'b0, 1'b1, 16'h000A);
    for (int i = 0; i < 50; i++) rand_cycle();

    @(negedge clk);
    ImmValid = 1'b0;
    sb_q.push_back(exp_t'{valid: 1'b0, value: model_q});
    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sign_extend
